// File: rtl/demux_pkg.sv
// Shared types and helpers for the slot-buffered demultiplexer.
package demux_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Destination index width; a single-output demux still carries a 1-bit index.
    function automatic int idx_w(input int cnt);
        return (cnt <= 1) ? 1 : $clog2(cnt);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: EMPTY/FULL state plus a payload register that
// reloads on a write, including a write in the same cycle as a drain.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_t state, state_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (wr_en) state_next = SLOT_FULL;
            SLOT_FULL: begin
                // A refill wins over a drain, so the slot stays FULL.
                if (wr_en)         state_next = SLOT_FULL;
                else if (rd_ready) state_next = SLOT_EMPTY;
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_slot_buf.sv
// One-to-CNT dispatcher with a one-beat holding slot per output.
// Define DEMUX_SLOT_BUF_ERR_EN to get a registered pulse on out-of-range destinations.
module demux_slot_buf
    import demux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CNT   = 1,
    localparam int IDXW  = idx_w(CNT),
    localparam int OCCW  = $clog2(CNT + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDXW-1:0]  in_dest,
    input  logic [WIDTH-1:0] in_data,
    output logic [CNT-1:0]   out_valid,
    input  logic [CNT-1:0]   out_ready,
    output logic [WIDTH-1:0] out_data [CNT-1:0],
    output logic [OCCW-1:0]  occupancy,
    output logic             err
);

    logic            dest_ok;
    logic            slot_rdy;
    logic [CNT-1:0]  dec;
    logic [CNT-1:0]  wr_en;
    logic [CNT-1:0]  full_next;
    logic [OCCW-1:0] occ_next;

    // With a power-of-two CNT every index value names a real slot.
    if ((1 << IDXW) == CNT) begin : g_pow2
        assign dest_ok = 1'b1;
    end else begin : g_npow2
        assign dest_ok = (in_dest < IDXW'(CNT));
    end

    always_comb begin
        dec = '0;
        for (int i = 0; i < CNT; i++) begin
            dec[i] = (in_dest == IDXW'(i));
        end
    end

    // Out-of-range beats are always swallowed so the producer never stalls on them.
    assign slot_rdy  = |(dec & (~out_valid | out_ready));
    assign in_ready  = dest_ok ? slot_rdy : 1'b1;
    assign wr_en     = dec & {CNT{in_valid & in_ready}};
    assign full_next = wr_en | (out_valid & ~out_ready);

    for (genvar g = 0; g < CNT; g++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .resetn   (resetn),
            .wr_en    (wr_en[g]),
            .wr_data  (in_data),
            .rd_ready (out_ready[g]),
            .valid    (out_valid[g]),
            .data     (out_data[g])
        );
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < CNT; i++) begin
            occ_next = occ_next + OCCW'(full_next[i]);
        end
    end

    // ---- p1: registered occupancy and error flag ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

`ifdef DEMUX_SLOT_BUF_ERR_EN
    logic err_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= in_valid & ~dest_ok;
        end
    end

    assign err = err_p1;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_slot_buf.sv
// Directed bench for demux_slot_buf: a CNT=4 instance for dispatch/occupancy
// and a CNT=3 instance for out-of-range destinations.
module tb_demux_slot_buf;

`ifdef DEMUX_SLOT_BUF_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;

    logic        iv4, ir4, err4;
    logic [1:0]  id4;
    logic [31:0] d4;
    logic [3:0]  ov4, or4;
    logic [31:0] od4 [3:0];
    logic [2:0]  occ4;

    logic        iv3, ir3, err3;
    logic [1:0]  id3;
    logic [31:0] d3;
    logic [2:0]  ov3, or3;
    logic [31:0] od3 [2:0];
    logic [1:0]  occ3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_slot_buf #(.WIDTH(32), .CNT(4)) u4 (
        .clk(clk), .resetn(resetn),
        .in_valid(iv4), .in_ready(ir4), .in_dest(id4), .in_data(d4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .occupancy(occ4), .err(err4)
    );

    demux_slot_buf #(.WIDTH(32), .CNT(3)) u3 (
        .clk(clk), .resetn(resetn),
        .in_valid(iv3), .in_ready(ir3), .in_dest(id3), .in_data(d3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3),
        .occupancy(occ3), .err(err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        iv4 = 1'b1; id4 = 2'd0; d4 = 32'h11; or4 = 4'b0000;
        iv3 = 1'b0; id3 = 2'd0; d3 = 32'h0;  or3 = 3'b000;

        // Reset with a beat already offered
        #12;
        chk("rst_valid", ov4, 4'b0000);
        chk("rst_occ", occ4, 3'd0);
        chk("rst_ready", ir4, 1'b1);
        chk("rst_err", err4, 1'b0);
        #10 resetn = 1'b1;
        step();
        chk("first_valid", ov4, 4'b0001);
        chk("first_data", od4[0], 32'h11);
        chk("first_occ", occ4, 3'd1);
        iv4 = 1'b0; or4 = 4'b0001;
        step();
        chk("first_drain", ov4, 4'b0000);
        chk("first_drain_occ", occ4, 3'd0);
        or4 = 4'b0000;

        // Backpressure on a full slot, then drain-and-refill
        iv4 = 1'b1; id4 = 2'd2; d4 = 32'hA5;
        step();
        chk("bp_valid", ov4, 4'b0100);
        chk("bp_data", od4[2], 32'hA5);
        chk("bp_occ", occ4, 3'd1);
        d4 = 32'h5A;
        #1 chk("bp_ready0", ir4, 1'b0);
        step();
        chk("bp_hold", od4[2], 32'hA5);
        chk("bp_ready1", ir4, 1'b0);
        or4 = 4'b0100;
        #1 chk("bp_ready_rel", ir4, 1'b1);
        step();
        chk("bp_refill_v", ov4, 4'b0100);
        chk("bp_refill_d", od4[2], 32'h5A);
        chk("bp_refill_occ", occ4, 3'd1);
        iv4 = 1'b0;
        step();
        chk("bp_empty_occ", occ4, 3'd0);
        or4 = 4'b0000;

        // Simultaneous drain and refill on slot 1
        iv4 = 1'b1; id4 = 2'd1; d4 = 32'h77;
        step();
        d4 = 32'h33; or4 = 4'b0010;
        #1 chk("dr_ready", ir4, 1'b1);
        step();
        chk("dr_valid", ov4, 4'b0010);
        chk("dr_data", od4[1], 32'h33);
        chk("dr_occ", occ4, 3'd1);
        iv4 = 1'b0;
        step();
        chk("dr_empty", occ4, 3'd0);
        or4 = 4'b0000;

        // Fill all four slots, then drain all at once
        iv4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id4 = 2'(i); d4 = 32'h100 + 32'(i);
            step();
            chk("fill_occ", occ4, 64'(i + 1));
        end
        iv4 = 1'b0; id4 = 2'd0;
        #1;
        chk("fill_valid", ov4, 4'b1111);
        chk("fill_data3", od4[3], 32'h103);
        chk("fill_ready", ir4, 1'b0);
        or4 = 4'b1111;
        step();
        chk("drain_occ", occ4, 3'd0);
        chk("drain_valid", ov4, 4'b0000);
        or4 = 4'b0000;

        // Asynchronous reset mid-cycle with three slots full
        iv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id4 = 2'(i); d4 = 32'h200 + 32'(i);
            step();
        end
        iv4 = 1'b0;
        chk("pre_rst_occ", occ4, 3'd3);
        #3 resetn = 1'b0;
        #1;
        chk("arst_valid", ov4, 4'b0000);
        chk("arst_occ", occ4, 3'd0);
        chk("arst_data", od4[0], 32'h0);
        #2 resetn = 1'b1;
        step();

        // Out-of-range destination on the CNT=3 instance
        iv3 = 1'b1; id3 = 2'd3; d3 = 32'hDEAD;
        #1 chk("oor_ready", ir3, 1'b1);
        step();
        chk("oor_err", err3, ERR_EN);
        chk("oor_valid", ov3, 3'b000);
        chk("oor_occ", occ3, 2'd0);
        step();
        chk("oor_err_b2b", err3, ERR_EN);
        iv3 = 1'b0;
        step();
        chk("oor_err_clr", err3, 1'b0);
        iv3 = 1'b1; id3 = 2'd2; d3 = 32'hBEEF;
        step();
        chk("c3_valid", ov3, 3'b100);
        chk("c3_data", od3[2], 32'hBEEF);
        chk("c3_occ", occ3, 2'd1);
        chk("c3_err", err3, 1'b0);
        iv3 = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
